// File: rtl/if_id_stall_ctrl_pkg.sv
// Shared front-end definitions: NOP encoding, PC step and the fetch-control FSM states.
package if_id_stall_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_stall_ctrl.sv
// Front-end pipeline control: owns PC and IF/ID, arbitrates mem stall, load-use stall
// and branch flush, and keeps saturating stall/flush performance counters.
module if_id_stall_ctrl
  import if_id_stall_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_target_i,
  input  logic             mem_stall_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             id_ex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  logic stall_eff;
  logic mem_act, stall_act, flush_act, fetch_act;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start_i) state_d = RUN;
  end

  // A load-use request against a bubble in ID has nothing to protect, so it is dropped.
  assign stall_eff = stall_i & if_valid_q;

  always_comb begin
    mem_act   = 1'b0;
    stall_act = 1'b0;
    flush_act = 1'b0;
    fetch_act = 1'b0;
    if (state_q == RUN) begin
      if (mem_stall_i)    mem_act   = 1'b1;
      else if (stall_eff) stall_act = 1'b1;
      else if (flush_i)   flush_act = 1'b1;
      else                fetch_act = 1'b1;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if (flush_act) begin
      pc_d       = branch_target_i;
      if_pc_d    = pc_q;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (fetch_act) begin
      pc_d       = pc_q + PC_INC;
      if_pc_d    = pc_q;
      if_instr_d = instr_i;
      if_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(stall_act), .cnt_o(stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mem_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(mem_act), .cnt_o(mem_stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(flush_act), .cnt_o(flush_cnt_o)
  );

  assign pc_o           = pc_q;
  assign if_id_pc_o     = if_pc_q;
  assign if_id_instr_o  = if_instr_q;
  assign if_id_valid_o  = if_valid_q;
  assign id_ex_bubble_o = stall_act;

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Bench for if_id_stall_ctrl: directed vector table, saturation and async-reset sequences,
// then random stimulus against a cycle-level behavioural model.
module tb_if_id_stall_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stall, flush, mem_stall;
  logic [31:0]      target;
  logic [31:0]      instr;
  logic [31:0]      pc, if_pc, if_instr;
  logic             if_valid, bubble;
  logic [CNT_W-1:0] stall_cnt, mem_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0001;
  endfunction

  assign instr = imem(pc);

  if_id_stall_ctrl #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(target), .mem_stall_i(mem_stall), .instr_i(instr),
    .pc_o(pc), .if_id_pc_o(if_pc), .if_id_instr_o(if_instr), .if_id_valid_o(if_valid),
    .id_ex_bubble_o(bubble), .stall_cnt_o(stall_cnt), .mem_stall_cnt_o(mem_cnt),
    .flush_cnt_o(flush_cnt)
  );

  // Behavioural model of the front end, stepped once per clock.
  bit          m_run;
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  bit          m_ifvalid;
  int          m_sc, m_mc, m_fc;

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = NOP; m_ifvalid = 0;
    m_sc = 0; m_mc = 0; m_fc = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  task automatic model_step(input logic st, sl, fl, ms, input logic [31:0] tg);
    if (!m_run) begin
      if (st) m_run = 1;
    end else if (ms) begin
      m_mc = sat_inc(m_mc);
    end else if (sl && m_ifvalid) begin
      m_sc = sat_inc(m_sc);
    end else if (fl) begin
      m_ifpc = m_pc; m_ifinstr = NOP; m_ifvalid = 0; m_pc = tg;
      m_fc = sat_inc(m_fc);
    end else begin
      m_ifpc = m_pc; m_ifinstr = imem(m_pc); m_ifvalid = 1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check("pc", pc, m_pc);
    check("if_pc", if_pc, m_ifpc);
    check("if_instr", if_instr, m_ifinstr);
    check("if_valid", 32'(if_valid), 32'(m_ifvalid));
    check("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    check("mem_cnt", 32'(mem_cnt), 32'(m_mc));
    check("flush_cnt", 32'(flush_cnt), 32'(m_fc));
  endtask

  // Drive one cycle of inputs, check the combinational bubble before the edge, then the state after.
  task automatic cycle(input logic st, sl, fl, ms, input logic [31:0] tg, output logic bub_seen);
    @(negedge clk);
    start = st; stall = sl; flush = fl; mem_stall = ms; target = tg;
    #1;
    bub_seen = bubble;
    check("bubble", 32'(bubble), 32'(m_run && !ms && sl && m_ifvalid));
    model_step(st, sl, fl, ms, tg);
    @(posedge clk);
    #1;
    check_state();
  endtask

  typedef struct {
    logic        st, sl, fl, ms;
    logic [31:0] tg;
    logic        bub;
    logic [31:0] pc, ifpc;
    logic        valid;
    int          sc, mc, fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, sl, fl, ms, input logic [31:0] tg, input logic bub,
                     input logic [31:0] p, ip, input logic v, input int s, m, f);
    vec_t r;
    r.st = st; r.sl = sl; r.fl = fl; r.ms = ms; r.tg = tg; r.bub = bub;
    r.pc = p; r.ifpc = ip; r.valid = v; r.sc = s; r.mc = m; r.fc = f;
    vecs.push_back(r);
  endtask

  logic b;

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; flush = 0; mem_stall = 0; target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    check("bubble_reset", 32'(bubble), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    //   st sl fl ms target         bub pc             ifpc           v  sc mc fc
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0,         0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,          0, 32'h0,         32'h0,         0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h4,         32'h0,         1, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,          0, 32'h8,         32'h4,         1, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'hC,         32'h8,         1, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h10,        32'hC,         1, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,          1, 32'h10,        32'hC,         1, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h14,        32'h10,        1, 1, 0, 0);
    add(0, 0, 1, 0, 32'h40,         0, 32'h40,        32'h14,        0, 1, 0, 1);
    add(0, 1, 0, 0, 32'h0,          0, 32'h44,        32'h40,        1, 1, 0, 1);
    for (int i = 1; i <= 3; i++)
      add(0, 1, 1, 1, 32'h80,       0, 32'h44,        32'h40,        1, 1, i, 1);
    add(0, 1, 1, 0, 32'h80,         1, 32'h44,        32'h40,        1, 2, 3, 1);
    add(0, 0, 1, 0, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC, 32'h44,        0, 2, 3, 2);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,         32'hFFFF_FFFC, 1, 2, 3, 2);
    add(0, 0, 0, 0, 32'h0,          0, 32'h4,         32'h0,         1, 2, 3, 2);

    foreach (vecs[i]) begin
      cycle(vecs[i].st, vecs[i].sl, vecs[i].fl, vecs[i].ms, vecs[i].tg, b);
      check($sformatf("vec%0d_bub", i), 32'(b), 32'(vecs[i].bub));
      check($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      check($sformatf("vec%0d_ifpc", i), if_pc, vecs[i].ifpc);
      check($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_cnts", i), {8'(stall_cnt), 8'(mem_cnt), 8'(flush_cnt)},
            {8'(vecs[i].sc), 8'(vecs[i].mc), 8'(vecs[i].fc)});
    end

    // Hold mem stall and load-use stall well past the counter range: both must stick at max.
    for (int i = 0; i < CNT_MAX + 5; i++) cycle(0, 1, 1, 1, 32'h100, b);
    for (int i = 0; i < CNT_MAX + 5; i++) cycle(0, 1, 0, 0, 32'h0, b);
    check("mem_cnt_sat", 32'(mem_cnt), CNT_MAX);
    check("stall_cnt_sat", 32'(stall_cnt), CNT_MAX);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom & 32'hFFFF_FFFC, b);

    // Asynchronous reset asserted mid-cycle, away from any clock edge.
    @(negedge clk);
    stall = 1; flush = 0; mem_stall = 0; start = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    check("bubble_async_rst", 32'(bubble), 32'h0);
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 32'h200, b);
    cycle(1, 0, 0, 0, 32'h0, b);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'h0, b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stall_ctrl.md
# if_id_stall_ctrl

Front-end pipeline control for the 5-stage CPU. It consumes the load-use `stall` request from hazard detection, plus the branch flush and data-memory busy signals. It owns the PC register and the IF/ID pipeline register, and tells the ID/EX register when to load a bubble. It also keeps saturating counters of stall and flush cycles for performance debug.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-low.
- `start_i` in 1: level; the CPU begins fetching on the first cycle it is sampled high.
- `stall_i` in 1: load-use stall request from hazard detection.
- `flush_i` in 1: branch taken, resolved in ID.
- `branch_target_i` in 32: next PC when `flush_i` is accepted.
- `mem_stall_i` in 1: data memory busy; freezes the whole front end.
- `instr_i` in 32: instruction memory read data for `pc_o` (combinational, same cycle).
- `pc_o` out 32: current fetch address.
- `if_id_pc_o` out 32: PC of the instruction held in IF/ID.
- `if_id_instr_o` out 32: instruction held in IF/ID.
- `if_id_valid_o` out 1: IF/ID holds a real instruction.
- `id_ex_bubble_o` out 1: ID/EX must load zeroed control this cycle.
- `stall_cnt_o` out CNT_W: number of accepted load-use stall cycles.
- `mem_stall_cnt_o` out CNT_W: number of mem-stall cycles.
- `flush_cnt_o` out CNT_W: number of accepted flushes.

## Operation
- Two-state FSM.
  - `IDLE`: the reset state. `pc_o` holds `RESET_PC`, IF/ID holds NOP, valid is 0, no counting. Moves to `RUN` in the cycle after `start_i` is sampled high.
  - `RUN`: stays in `RUN` until reset. `start_i` is ignored once in `RUN`.
- Effective stall: `stall_eff = stall_i & if_id_valid_o`. A stall request against a bubble in ID is ignored.
- `RUN` priority per cycle, highest first:
  1. `mem_stall_i`: PC and IF/ID hold. `id_ex_bubble_o`=0 (ID/EX is frozen by the same signal). `mem_stall_cnt` increments.
  2. `stall_eff`: PC and IF/ID hold. `id_ex_bubble_o`=1. `stall_cnt` increments. `flush_i` is ignored this cycle, because the branch operands are not ready and the branch re-resolves next cycle.
  3. `flush_i`: `pc <= branch_target_i`. IF/ID gets `{pc_o, NOP_INSTR}` with valid=0. `flush_cnt` increments.
  4. Otherwise: `pc <= pc_o + 4` (32-bit wrap, 32'hFFFF_FFFC goes to 0). IF/ID gets `{pc_o, instr_i}` with valid=1.
- `id_ex_bubble_o` is combinational: `RUN & ~mem_stall_i & stall_eff`. It is 0 in `IDLE`.
- Counters saturate at all-ones and never wrap. They only count in `RUN`.
- `branch_target_i` is used as given; misalignment is not checked.

## Timing
- Reset values: `pc_o`=`RESET_PC`, `if_id_pc_o`=0, `if_id_instr_o`=`NOP_INSTR`, `if_id_valid_o`=0, `id_ex_bubble_o`=0, all counters 0, state `IDLE`.
- Reset applied mid-operation: all of the above take effect immediately (asynchronous), regardless of clock.
- Fetch latency: the instruction at `pc_o` appears in IF/ID one cycle after a non-held cycle.
- A single-cycle `stall_eff` delays IF/ID by exactly one cycle and inserts exactly one bubble.
- Flush penalty: exactly one invalid IF/ID slot. The target instruction is in IF/ID two cycles after the flush is accepted.
- Simultaneous `mem_stall_i`, `stall_i` and `flush_i`: only the mem stall acts, and only `mem_stall_cnt` increments.

## Structure
- Shared CPU package holds `NOP_INSTR` = 32'h0000_0013, `PC_INC` = 4, and the FSM state enum (`IDLE`, `RUN`).
- One natural sub-module, `sat_counter`: parameterised width, with enable, async active-low reset and saturation. It is instantiated three times.
- The remaining logic (PC register, IF/ID register, FSM, priority mux) lives in this module.

## Test plan
- Reset, hold `start_i`=0 for 5 cycles, then assert it. Expect `pc_o`=0 throughout `IDLE`. `pc_o` becomes 4 two cycles after `start_i` is sampled, and the first valid IF/ID has pc 0.
- Straight-line fetch of 4 instructions, then a 1-cycle `stall_i`. Expect `pc_o` held at 16, `id_ex_bubble_o`=1 for exactly one cycle, and `stall_cnt_o`=1.
- `flush_i` with `branch_target_i`=32'h40. Expect `pc_o`=32'h40 next cycle, IF/ID = NOP with valid 0, then IF/ID pc=32'h40 valid 1, and `flush_cnt_o`=1.
- Assert `stall_i`, `flush_i` and `mem_stall_i` together for 3 cycles. Expect everything held, bubble 0, `mem_stall_cnt_o`=3, other counters unchanged. Then drop `mem_stall_i` with `stall_i` still high: expect bubble 1 and no flush.
- `stall_i`=1 while `if_id_valid_o`=0 (right after a flush). Expect no hold, no bubble, and `stall_cnt_o` unchanged.
- Force `pc_o`=32'hFFFF_FFFC through a flush, then run one cycle. Expect wrap to 0. Pulse `rst_i` low mid-cycle: expect outputs back to reset values immediately.
